// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Multi-cycle data-memory responder for the Memory stage. Accepts
//             a load/store request, waits LATENCY cycles, then performs the
//             access on an internal word RAM. MemStall freezes the pipeline
//             while the access is pending.
//  Ports    : clk, reset (async, active-high)
//             MemReadM / MemWriteM / ByteM  - request controls (write wins)
//             AddrM [31:0], WriteDataM [31:0] - byte address, store data
//             ReadData [31:0]  - registered load result
//             MemStall         - access pending
//             MemDone          - one-cycle completion pulse
//             AlignFault       - one-cycle misaligned-word pulse (in DONE)
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        MemStall,
    output logic        MemDone,
    output logic        AlignFault
);

    localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic                    r_is_wr;
    logic                    r_byte;
    logic [DEPTH_LOG2+1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [31:0]             r_mem [0:c_DEPTH-1];

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [4:0]              w_lane_bit;
    logic                    w_misaligned;
    logic                    w_access;
    logic                    w_ram_we;
    logic [31:0]             w_rd_word;
    logic [7:0]              w_rd_byte;
    logic                    w_unused_addr;

    // Address bits above the RAM span are ignored, so accesses wrap.
    assign w_unused_addr = ^AddrM[31:DEPTH_LOG2+2];

    assign w_idx        = r_addr[DEPTH_LOG2+1:2];
    assign w_lane_bit   = {r_addr[1:0], 3'b000};
    assign w_misaligned = !r_byte && (r_addr[1:0] != 2'b00);
    assign w_access     = (r_state == ST_WAIT) && (r_cnt == 4'd0);
    assign w_ram_we     = w_access && r_is_wr && !w_misaligned;
    assign w_rd_word    = r_mem[w_idx];
    assign w_rd_byte    = w_rd_word[w_lane_bit +: 8];

    // Stall is combinational in IDLE so the hazard unit can freeze the
    // pipeline in the same cycle the request first appears.
    always_comb begin
        MemStall = 1'b0;
        case (r_state)
            ST_IDLE: MemStall = MemReadM | MemWriteM;
            ST_WAIT: MemStall = 1'b1;
            default: MemStall = 1'b0;
        endcase
    end

    // RAM has no reset; contents survive a mid-operation reset. Because the
    // state register resets asynchronously, a pending store can never
    // reach its write edge once reset is seen.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            if (r_byte) begin
                r_mem[w_idx][w_lane_bit +: 8] <= r_wdata[7:0];
            end else begin
                r_mem[w_idx] <= r_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_is_wr    <= 1'b0;
            r_byte     <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            ReadData   <= 32'd0;
            MemDone    <= 1'b0;
            AlignFault <= 1'b0;
        end else begin
            MemDone    <= 1'b0;
            AlignFault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MemReadM || MemWriteM) begin
                        // A store takes priority over a simultaneous load.
                        r_is_wr <= MemWriteM;
                        r_byte  <= ByteM;
                        r_addr  <= AddrM[DEPTH_LOG2+1:0];
                        r_wdata <= WriteDataM;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_is_wr) begin
                            if (w_misaligned) begin
                                ReadData <= 32'd0;
                            end else if (r_byte) begin
                                ReadData <= {24'd0, w_rd_byte};
                            end else begin
                                ReadData <= w_rd_word;
                            end
                        end
                        MemDone    <= 1'b1;
                        AlignFault <= w_misaligned;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // The old request is still visible here; returning to IDLE
                // without looking at it prevents a duplicate access.
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder. Three instances with
//             LATENCY 2, 1 and 5 are compared against a behavioural memory
//             model using directed cases and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int N = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         rd_s, wr_s, byte_s, stall_s, done_s, fault_s;
    logic [N-1:0][31:0]   addr_s, wdata_s, rdata_s;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_mem   [N][64];
    logic [31:0] m_rdata [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2 (6),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 5))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .MemReadM   (rd_s[g]),
            .MemWriteM  (wr_s[g]),
            .ByteM      (byte_s[g]),
            .AddrM      (addr_s[g]),
            .WriteDataM (wdata_s[g]),
            .ReadData   (rdata_s[g]),
            .MemStall   (stall_s[g]),
            .MemDone    (done_s[g]),
            .AlignFault (fault_s[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural effect of one access on the model memory / result.
    task automatic model_op(input int k, input logic is_wr, input logic byt,
                            input logic [31:0] addr, input logic [31:0] data,
                            output logic fault);
        int          idx;
        int          lane;
        logic [31:0] mask;
        idx   = int'(addr[7:2]);
        lane  = int'(addr[1:0]);
        fault = !byt && (lane != 0);
        mask  = 32'hFF << (8 * lane);
        if (is_wr) begin
            if (!fault) begin
                if (byt) m_mem[k][idx] = (m_mem[k][idx] & ~mask) | ({24'd0, data[7:0]} << (8 * lane));
                else     m_mem[k][idx] = data;
            end
        end else if (fault) begin
            m_rdata[k] = 32'd0;
        end else if (byt) begin
            m_rdata[k] = (m_mem[k][idx] >> (8 * lane)) & 32'hFF;
        end else begin
            m_rdata[k] = m_mem[k][idx];
        end
    endtask

    // Full transaction: request held through DONE, dropped right after.
    task automatic do_access(input int k, input logic rd, input logic wr, input logic byt,
                             input logic [31:0] addr, input logic [31:0] data);
        int          lat;
        int          n_stall;
        int          n_done;
        logic [31:0] old_rd;
        logic        exp_fault;
        lat     = lat_of(k);
        n_stall = 0;
        n_done  = 0;
        old_rd  = m_rdata[k];
        model_op(k, wr, byt, addr, data, exp_fault);
        @(posedge clk);
        #1;
        rd_s[k] = rd; wr_s[k] = wr; byte_s[k] = byt; addr_s[k] = addr; wdata_s[k] = data;
        for (int c = 0; c <= lat + 1; c++) begin
            @(negedge clk);
            n_stall += int'(stall_s[k]);
            n_done  += int'(done_s[k]);
            if (c <= lat) begin
                check("stall_pending", 32'(stall_s[k]), 32'd1);
                check("rdata_hold",    rdata_s[k],      old_rd);
                check("done_early",    32'(done_s[k]),  32'd0);
                check("fault_early",   32'(fault_s[k]), 32'd0);
            end else begin
                check("stall_done",    32'(stall_s[k]), 32'd0);
                check("done_pulse",    32'(done_s[k]),  32'd1);
                check("rdata",         rdata_s[k],      m_rdata[k]);
                check("fault",         32'(fault_s[k]), 32'(exp_fault));
            end
            @(posedge clk);
        end
        #1;
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        @(negedge clk);
        n_stall += int'(stall_s[k]);
        n_done  += int'(done_s[k]);
        check("stall_len",  32'(n_stall), 32'(lat + 1));
        check("done_count", 32'(n_done),  32'd1);
        check("rdata_idle", rdata_s[k],   m_rdata[k]);
    endtask

    initial begin
        logic [31:0] old40;
        reset = 1'b1;
        rd_s = '0; wr_s = '0; byte_s = '0; addr_s = '0; wdata_s = '0;
        for (int k = 0; k < N; k++) m_rdata[k] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            check("rst_rdata", rdata_s[k],       32'd0);
            check("rst_stall", 32'(stall_s[k]),  32'd0);
            check("rst_done",  32'(done_s[k]),   32'd0);
            check("rst_fault", 32'(fault_s[k]),  32'd0);
        end
        reset = 1'b0;

        // Give every word a known value in every instance.
        for (int k = 0; k < N; k++)
            for (int w = 0; w < 64; w++)
                do_access(k, 1'b0, 1'b1, 1'b0, 32'(w * 4), $urandom);

        // Word store then load.
        do_access(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        do_access(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        check("word_load", rdata_s[0], 32'hDEADBEEF);

        // Byte lanes.
        do_access(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h11223344);
        do_access(0, 1'b0, 1'b1, 1'b1, 32'h22, 32'hFFFFFFAB);
        do_access(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        check("lane_word", rdata_s[0], 32'h11AB3344);
        do_access(0, 1'b1, 1'b0, 1'b1, 32'h23, 32'h0);
        check("lane_byte", rdata_s[0], 32'h00000011);

        // Misaligned accesses.
        do_access(0, 1'b0, 1'b1, 1'b0, 32'h30, 32'hCAFEF00D);
        do_access(0, 1'b0, 1'b1, 1'b0, 32'h31, 32'h12345678);
        do_access(0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0);
        check("misalign_keep", rdata_s[0], 32'hCAFEF00D);
        do_access(0, 1'b1, 1'b0, 1'b0, 32'h32, 32'h0);
        check("misalign_zero", rdata_s[0], 32'h0);

        // Read/write conflict and address wrap.
        do_access(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h5);
        check("conflict_hold", rdata_s[0], 32'h0);
        do_access(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("wrap_load", rdata_s[0], 32'h5);

        // Reset in the second WAIT cycle discards the pending store.
        old40 = m_mem[0][16];
        @(posedge clk);
        #1;
        wr_s[0] = 1'b1; byte_s[0] = 1'b0; addr_s[0] = 32'h40; wdata_s[0] = 32'h77;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr_s[0] = 1'b0;
        for (int k = 0; k < N; k++) m_rdata[k] = 32'd0;
        @(negedge clk);
        check("rstw_stall", 32'(stall_s[0]), 32'd0);
        check("rstw_rdata", rdata_s[0],      32'd0);
        check("rstw_done",  32'(done_s[0]),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rstw_idle", 32'(stall_s[0]), 32'd0);
        do_access(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        check("rstw_old", rdata_s[0], old40);

        // Request withdrawn in IDLE before the edge is not accepted.
        @(posedge clk);
        #1;
        rd_s[0] = 1'b1; addr_s[0] = 32'h8;
        @(negedge clk);
        check("withdraw_stall", 32'(stall_s[0]), 32'd1);
        #1;
        rd_s[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("withdraw_idle", 32'(stall_s[0]), 32'd0);
            check("withdraw_done", 32'(done_s[0]),  32'd0);
        end

        // Random traffic on all latencies.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                int op;
                op = int'($urandom_range(0, 2));
                do_access(k, op != 1, op != 0, 1'($urandom), $urandom, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
